// File: rtl/window_pkg.sv
// Shared parameters and types for the window feeder and the shifting window array.
// Holds pixel width, window size defaults, the pixel type and the feeder state type.
package window_pkg;

  localparam int PIXEL_WIDTH = 30;
  localparam int WINDOW_W    = 9;
  localparam int WINDOW_H    = 9;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } feed_state_e;

endpackage

// File: rtl/line_buffer_row.sv
// One image row of pixel storage with read-before-write at a single address.
// Ports: clock, wr_en, addr, wr_data in; rd_data out (old contents at addr).
module line_buffer_row #(
  parameter int PIXEL_WIDTH = 30,
  parameter int IMG_W       = 28
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic [PIXEL_WIDTH-1:0]   wr_data,
  output logic [PIXEL_WIDTH-1:0]   rd_data
);
  import window_pkg::*;

  logic [PIXEL_WIDTH-1:0] mem [IMG_W];

  // Contents are deliberately not reset; stale data is masked upstream.
  assign rd_data = mem[addr];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_line_feeder.sv
// Raster pixel stream to WINDOW_H-tall columns for the shifting window array.
// Ports: clock/reset, in_valid/in_ready/in_pixel/in_sof/hold in; col_out, shift_en,
// shift_dir, window_valid, win_row, win_col, frame_done out.
module window_line_feeder #(
  parameter int PIXEL_WIDTH = window_pkg::PIXEL_WIDTH,
  parameter int WINDOW_W    = window_pkg::WINDOW_W,
  parameter int WINDOW_H    = window_pkg::WINDOW_H,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PIXEL_WIDTH-1:0]          in_pixel,
  input  logic                            in_sof,
  input  logic                            hold,
  output logic [WINDOW_H*PIXEL_WIDTH-1:0] col_out,
  output logic                            shift_en,
  output logic                            shift_dir,
  output logic                            window_valid,
  output logic [$clog2(IMG_H)-1:0]        win_row,
  output logic [$clog2(IMG_W)-1:0]        win_col,
  output logic                            frame_done
);
  import window_pkg::*;

  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(IMG_W);
  localparam int PW  = PIXEL_WIDTH;
  localparam int NLB = WINDOW_H - 1;

  localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
  localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
  localparam logic [RW-1:0] MIN_R  = RW'(WINDOW_H - 1);
  localparam logic [CW-1:0] MIN_C  = CW'(WINDOW_W - 1);

  feed_state_e state, state_next;

  logic [RW-1:0] row, r_next, pos_r;
  logic [CW-1:0] col, c_next, pos_c;

  logic run_en;
  logic accept;
  logic take;
  logic at_last;
  logic edge_ok;

  logic [PW-1:0] lb_wr [NLB];
  logic [PW-1:0] lb_rd [NLB];

  logic [WINDOW_H*PW-1:0] col_bus;

  // run_en keeps in_ready low while reset is held and for the first edge after.
  assign in_ready = run_en && !hold && (state != ST_DONE);
  assign accept   = in_valid && in_ready;

  // Non-sof pixels in IDLE are accepted but dropped.
  assign take     = accept && (in_sof || state == ST_RUN);

  // sof forces (0,0) for this pixel, which also aborts a frame in progress.
  assign pos_r    = in_sof ? '0 : row;
  assign pos_c    = in_sof ? '0 : col;
  assign at_last  = (pos_r == LAST_R) && (pos_c == LAST_C);
  assign edge_ok  = (pos_r >= MIN_R) && (pos_c >= MIN_C);

  assign shift_dir  = 1'b1;
  assign frame_done = (state == ST_DONE);

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (take) begin
          state_next = at_last ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (take && at_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    r_next = row;
    c_next = col;
    if (take) begin
      if (at_last) begin
        r_next = '0;
        c_next = '0;
      end else if (pos_c == LAST_C) begin
        r_next = pos_r + RW'(1);
        c_next = '0;
      end else begin
        r_next = pos_r;
        c_next = pos_c + CW'(1);
      end
    end
  end

  // Buffers form a vertical shift chain per column: each passes its old value down.
  always_comb begin
    lb_wr[0] = in_pixel;
    for (int k = 1; k < NLB; k++) begin
      lb_wr[k] = lb_rd[k-1];
    end
  end

  always_comb begin
    col_bus = '0;
    col_bus[PW-1:0] = in_pixel;
    for (int k = 1; k < WINDOW_H; k++) begin
      col_bus[k*PW +: PW] = lb_rd[k-1];
    end
  end

  for (genvar k = 0; k < NLB; k++) begin : g_lb
    line_buffer_row #(
      .PIXEL_WIDTH (PW),
      .IMG_W       (IMG_W)
    ) u_lb (
      .clock   (clock),
      .wr_en   (take),
      .addr    (pos_c),
      .wr_data (lb_wr[k]),
      .rd_data (lb_rd[k])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      row   <= '0;
      col   <= '0;
      run_en <= 1'b0;
    end else begin
      state <= state_next;
      row   <= r_next;
      col   <= c_next;
      run_en <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_en     <= 1'b0;
      window_valid <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
      col_out      <= '0;
    end else begin
      shift_en     <= take;
      window_valid <= take && edge_ok;
      if (take) begin
        win_row <= pos_r;
        win_col <= pos_c;
        col_out <= col_bus;
      end
    end
  end

endmodule

// File: tb/tb_window_line_feeder.sv
// Directed bench for window_line_feeder on a 16x16 image with a 9x9 window.
// Expected outputs are queued per accepted pixel and checked the cycle after.
module tb_window_line_feeder;

  localparam int PW = 30;
  localparam int WW = 9;
  localparam int WH = 9;
  localparam int IW = 16;
  localparam int IH = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic hold = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic in_ready;
  logic shift_en;
  logic shift_dir;
  logic window_valid;
  logic frame_done;
  logic [WH*PW-1:0] col_out;
  logic [3:0] win_row;
  logic [3:0] win_col;

  always #5 clock = ~clock;

  window_line_feeder #(
    .PIXEL_WIDTH (PW),
    .WINDOW_W    (WW),
    .WINDOW_H    (WH),
    .IMG_W       (IW),
    .IMG_H       (IH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixel     (in_pixel),
    .in_sof       (in_sof),
    .hold         (hold),
    .col_out      (col_out),
    .shift_en     (shift_en),
    .shift_dir    (shift_dir),
    .window_valid (window_valid),
    .win_row      (win_row),
    .win_col      (win_col),
    .frame_done   (frame_done)
  );

  typedef struct packed {
    logic [WH-1:0][PW-1:0] col;
    logic [WH-1:0]         known;
    logic                  wv;
    logic [3:0]            r;
    logic [3:0]            c;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passed = 0;
  int fails = 0;

  int mstate = 0;
  int mr = 0;
  int mc = 0;
  bit men = 1'b0;
  logic [PW-1:0] hist [IW][WH-1];
  int depth [IW];

  int n_shift = 0;
  int n_wv = 0;
  int n_done = 0;
  int first_r = -1;
  int first_c = -1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_shift = 0;
    n_wv = 0;
    n_done = 0;
    first_r = -1;
    first_c = -1;
  endtask

  task automatic model_step(input logic acc, input logic [PW-1:0] px,
                            input logic sof);
    exp_t e;
    int pr;
    int pc;
    if (mstate == 2) begin
      mstate = 0;
    end else if (acc && (mstate == 1 || sof)) begin
      pr = sof ? 0 : mr;
      pc = sof ? 0 : mc;
      e = '0;
      e.col[0] = px;
      e.known[0] = 1'b1;
      for (int k = 1; k < WH; k++) begin
        if (depth[pc] >= k) begin
          e.col[k] = hist[pc][k-1];
          e.known[k] = 1'b1;
        end
      end
      for (int k = WH - 2; k > 0; k--) begin
        hist[pc][k] = hist[pc][k-1];
      end
      hist[pc][0] = px;
      if (depth[pc] < WH - 1) depth[pc]++;
      e.wv = (pr >= WH - 1) && (pc >= WW - 1);
      e.r = 4'(pr);
      e.c = 4'(pc);
      sb.push_back(e);
      if (pr == IH - 1 && pc == IW - 1) begin
        mr = 0;
        mc = 0;
        mstate = 2;
      end else begin
        mstate = 1;
        if (pc == IW - 1) begin
          mc = 0;
          mr = pr + 1;
        end else begin
          mc = pc + 1;
          mr = pr;
        end
      end
    end
    men = 1'b1;
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("shift_en", 64'(shift_en), 64'd1);
      chk("window_valid", 64'(window_valid), 64'(e.wv));
      chk("win_row", 64'(win_row), 64'(e.r));
      chk("win_col", 64'(win_col), 64'(e.c));
      for (int k = 0; k < WH; k++) begin
        if (e.known[k]) begin
          chk("col_out", 64'(col_out[k*PW +: PW]), 64'(e.col[k]));
        end
        if (e.wv) begin
          chk("col_patch", 64'(col_out[k*PW +: PW]),
              64'((int'(e.r) - k) * 16 + int'(e.c)));
        end
      end
    end else begin
      chk("no_shift", 64'(shift_en), 64'd0);
    end
    chk("frame_done", 64'(frame_done), 64'(mstate == 2));
    if (shift_en) n_shift++;
    if (frame_done) n_done++;
    if (shift_en && window_valid) begin
      if (n_wv == 0) begin
        first_r = int'(win_row);
        first_c = int'(win_col);
      end
      n_wv++;
    end
  endtask

  task automatic cycle(input logic v, input logic [PW-1:0] px,
                       input logic sof, input logic h, output logic acc);
    logic rdy;
    @(negedge clock);
    in_valid = v;
    in_pixel = px;
    in_sof = sof;
    hold = h;
    #1;
    rdy = men && !h && (mstate != 2);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    acc = v && rdy;
    model_step(acc, px, sof);
    @(posedge clock);
    #1;
    sample();
  endtask

  task automatic send(input logic [PW-1:0] px, input logic sof);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 10 && !acc; t++) begin
      cycle(1'b1, px, sof, 1'b0, acc);
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic stream(input int a, input int b, input bit sof_first);
    for (int i = a; i <= b; i++) begin
      send(PW'(i), sof_first && (i == a));
    end
  endtask

  task automatic idle_cyc();
    logic acc;
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_shift_en", 64'(shift_en), 64'd0);
    chk("rst_window_valid", 64'(window_valid), 64'd0);
    chk("rst_col_out", 64'(col_out == '0), 64'd1);
    chk("rst_win_row", 64'(win_row), 64'd0);
    chk("rst_win_col", 64'(win_col), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_shift_dir", 64'(shift_dir), 64'd1);
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("ready_after_release", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    men = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_shift_count"}, 64'(n_shift), 64'd256);
    chk({tag, "_valid_count"}, 64'(n_wv), 64'd64);
    chk({tag, "_done_count"}, 64'(n_done), 64'd1);
    chk({tag, "_first_row"}, 64'(first_r), 64'd8);
    chk({tag, "_first_col"}, 64'(first_c), 64'd8);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    for (int c = 0; c < IW; c++) depth[c] = 0;

    // Reset values
    @(negedge clock);
    #1;
    check_reset_outputs();
    release_reset();

    // Full frame
    clr_counts();
    stream(0, 255, 1'b1);
    check_frame("frame1");
    idle_cyc();

    // Non-sof pixels in IDLE are accepted and dropped
    clr_counts();
    send(PW'(77), 1'b0);
    send(PW'(78), 1'b0);
    chk("idle_drop_shifts", 64'(n_shift), 64'd0);

    // Second frame with a hold at (10,3)
    stream(0, 10 * 16 + 2, 1'b1);
    for (int t = 0; t < 5; t++) begin
      cycle(1'b1, PW'(10 * 16 + 3), 1'b0, 1'b1, acc);
    end
    stream(10 * 16 + 3, 12 * 16 + 4, 1'b0);
    chk("frame2_shift_count", 64'(n_shift), 64'(12 * 16 + 5));

    // sof at (12,5) restarts the frame
    clr_counts();
    stream(0, 11 * 16 + 10, 1'b1);
    chk("abort_valid_count", 64'd27, 64'(n_wv));
    chk("abort_first_row", 64'(first_r), 64'd8);
    chk("abort_first_col", 64'(first_c), 64'd8);

    // Reset dropped while presenting (11,11)
    @(negedge clock);
    in_valid = 1'b1;
    in_pixel = PW'(11 * 16 + 11);
    #2;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs();
    mstate = 0;
    mr = 0;
    mc = 0;
    men = 1'b0;
    sb.delete();
    release_reset();

    // Fresh frame after reset
    clr_counts();
    stream(0, 255, 1'b1);
    check_frame("frame3");
    idle_cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
